// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and WB-to-ID register-file bypass.
// Latency: one cycle from ID inputs to _ex outputs; hazard and stall outputs are combinational.
// Backpressure: stall_ex holds the stage and load-use inserts one bubble; both freeze IF/ID, and flush_ex overrides them.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   *_id                           decoded instruction (PC, register indices, operands, immediate, control)
//   rd_wb, reg_write_wb, wb_data   write-back port, used to bypass/refresh operand data
//   flush_ex, stall_ex             EX redirect (kill) and back-end busy (hold)
//   *_ex                           registered instruction presented to EX and the forwarding unit
//   stall_if_id, load_use_hazard   combinational front-end freeze and hazard flag
//   bubble_count                   saturating count of inserted load-use bubbles
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             valid_id,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic [XLEN-1:0]  rs1_data_id,
  input  logic [XLEN-1:0]  rs2_data_id,
  input  logic [XLEN-1:0]  imm_id,
  input  logic [3:0]       alu_op_id,
  input  logic             alu_src_id,
  input  logic             mem_read_id,
  input  logic             mem_write_id,
  input  logic             reg_write_id,
  input  logic             mem_to_reg_id,
  input  logic             branch_id,
  input  logic             jump_id,

  input  logic [4:0]       rd_wb,
  input  logic             reg_write_wb,
  input  logic [XLEN-1:0]  wb_data,

  input  logic             flush_ex,
  input  logic             stall_ex,

  output logic             valid_ex,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  rs1_data_ex,
  output logic [XLEN-1:0]  rs2_data_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic [4:0]       rs1_ex,
  output logic [4:0]       rs2_ex,
  output logic [4:0]       rd_ex,
  output logic [3:0]       alu_op_ex,
  output logic             alu_src_ex,
  output logic             mem_read_ex,
  output logic             mem_write_ex,
  output logic             reg_write_ex,
  output logic             mem_to_reg_ex,
  output logic             branch_ex,
  output logic             jump_ex,

  output logic             stall_if_id,
  output logic             load_use_hazard,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic wb_hit_rs1_id;
  logic wb_hit_rs2_id;
  logic wb_hit_rs1_ex;
  logic wb_hit_rs2_ex;

  // A load in EX whose result an ID instruction genuinely reads cannot be
  // forwarded in time; x0 destinations never produce a value to wait for.
  assign load_use_hazard = valid_ex && mem_read_ex && (rd_ex != 5'd0) && valid_id &&
                           ((uses_rs1_id && (rd_ex == rs1_id)) ||
                            (uses_rs2_id && (rd_ex == rs2_id)));

  // A redirect kills whatever IF/ID holds, so freezing it would be pointless.
  assign stall_if_id = (load_use_hazard || stall_ex) && !flush_ex;

  // WB writes the register file in the same cycle ID reads it, so the read
  // data is stale; take the WB value instead. x0 is never bypassed.
  assign wb_hit_rs1_id = reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs1_id);
  assign wb_hit_rs2_id = reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs2_id);

  // While held, a producer may retire through WB; refresh the held operand so
  // it is still correct once the producer is no longer forwardable.
  assign wb_hit_rs1_ex = reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs1_ex);
  assign wb_hit_rs2_ex = reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs2_ex);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_ex      <= 1'b0;
      pc_ex         <= '0;
      rs1_data_ex   <= '0;
      rs2_data_ex   <= '0;
      imm_ex        <= '0;
      rs1_ex        <= 5'd0;
      rs2_ex        <= 5'd0;
      rd_ex         <= 5'd0;
      alu_op_ex     <= 4'd0;
      alu_src_ex    <= 1'b0;
      mem_read_ex   <= 1'b0;
      mem_write_ex  <= 1'b0;
      reg_write_ex  <= 1'b0;
      mem_to_reg_ex <= 1'b0;
      branch_ex     <= 1'b0;
      jump_ex       <= 1'b0;
      bubble_count  <= '0;
    end else if (flush_ex) begin
      // Redirect bubble: kill state-changing control and indices; data is don't-care.
      valid_ex      <= 1'b0;
      rs1_ex        <= 5'd0;
      rs2_ex        <= 5'd0;
      rd_ex         <= 5'd0;
      mem_read_ex   <= 1'b0;
      mem_write_ex  <= 1'b0;
      reg_write_ex  <= 1'b0;
      branch_ex     <= 1'b0;
      jump_ex       <= 1'b0;
    end else if (stall_ex) begin
      if (wb_hit_rs1_ex) rs1_data_ex <= wb_data;
      if (wb_hit_rs2_ex) rs2_data_ex <= wb_data;
    end else if (load_use_hazard) begin
      valid_ex      <= 1'b0;
      rs1_ex        <= 5'd0;
      rs2_ex        <= 5'd0;
      rd_ex         <= 5'd0;
      mem_read_ex   <= 1'b0;
      mem_write_ex  <= 1'b0;
      reg_write_ex  <= 1'b0;
      branch_ex     <= 1'b0;
      jump_ex       <= 1'b0;
      if (bubble_count != CNT_MAX) bubble_count <= bubble_count + 1'b1;
    end else begin
      valid_ex      <= valid_id;
      pc_ex         <= pc_id;
      rs1_data_ex   <= wb_hit_rs1_id ? wb_data : rs1_data_id;
      rs2_data_ex   <= wb_hit_rs2_id ? wb_data : rs2_data_id;
      imm_ex        <= imm_id;
      alu_op_ex     <= alu_op_id;
      alu_src_ex    <= alu_src_id;
      mem_to_reg_ex <= mem_to_reg_id;
      // An empty ID slot enters EX as a bubble so it cannot touch state.
      if (valid_id) begin
        rs1_ex       <= rs1_id;
        rs2_ex       <= rs2_id;
        rd_ex        <= rd_id;
        mem_read_ex  <= mem_read_id;
        mem_write_ex <= mem_write_id;
        reg_write_ex <= reg_write_id;
        branch_ex    <= branch_id;
        jump_ex      <= jump_id;
      end else begin
        rs1_ex       <= 5'd0;
        rs2_ex       <= 5'd0;
        rd_ex        <= 5'd0;
        mem_read_ex  <= 1'b0;
        mem_write_ex <= 1'b0;
        reg_write_ex <= 1'b0;
        branch_ex    <= 1'b0;
        jump_ex      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

  localparam int XLEN = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk;
  logic            rst;
  logic            valid_id;
  logic [XLEN-1:0] pc_id;
  logic [4:0]      rs1_id, rs2_id, rd_id;
  logic            uses_rs1_id, uses_rs2_id;
  logic [XLEN-1:0] rs1_data_id, rs2_data_id, imm_id;
  logic [3:0]      alu_op_id;
  logic            alu_src_id, mem_read_id, mem_write_id, reg_write_id;
  logic            mem_to_reg_id, branch_id, jump_id;
  logic [4:0]      rd_wb;
  logic            reg_write_wb;
  logic [XLEN-1:0] wb_data;
  logic            flush_ex, stall_ex;

  logic            valid_ex;
  logic [XLEN-1:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]      rs1_ex, rs2_ex, rd_ex;
  logic [3:0]      alu_op_ex;
  logic            alu_src_ex, mem_read_ex, mem_write_ex, reg_write_ex;
  logic            mem_to_reg_ex, branch_ex, jump_ex;
  logic            stall_if_id, load_use_hazard;
  logic [CW-1:0]   bubble_count;

  int tests = 0;
  int fails = 0;

  id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .valid_id(valid_id), .pc_id(pc_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .alu_op_id(alu_op_id), .alu_src_id(alu_src_id), .mem_read_id(mem_read_id),
    .mem_write_id(mem_write_id), .reg_write_id(reg_write_id),
    .mem_to_reg_id(mem_to_reg_id), .branch_id(branch_id), .jump_id(jump_id),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .wb_data(wb_data),
    .flush_ex(flush_ex), .stall_ex(stall_ex),
    .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex),
    .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .alu_op_ex(alu_op_ex), .alu_src_ex(alu_src_ex), .mem_read_ex(mem_read_ex),
    .mem_write_ex(mem_write_ex), .reg_write_ex(reg_write_ex),
    .mem_to_reg_ex(mem_to_reg_ex), .branch_ex(branch_ex), .jump_ex(jump_ex),
    .stall_if_id(stall_if_id), .load_use_hazard(load_use_hazard),
    .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected content of the EX slot. 'known' marks whether the don't-care
  // fields (PC, data, immediate, ALU control) are defined.
  typedef struct {
    logic            valid;
    logic [XLEN-1:0] pc, d1, d2, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      alu_op;
    logic            alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump;
    logic            known;
    int              cnt;
  } ex_model_t;

  ex_model_t m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; valid_id = 1'b0; pc_id = '0;
    rs1_id = 5'd0; rs2_id = 5'd0; rd_id = 5'd0;
    uses_rs1_id = 1'b0; uses_rs2_id = 1'b0;
    rs1_data_id = '0; rs2_data_id = '0; imm_id = '0; alu_op_id = 4'd0;
    alu_src_id = 1'b0; mem_read_id = 1'b0; mem_write_id = 1'b0; reg_write_id = 1'b0;
    mem_to_reg_id = 1'b0; branch_id = 1'b0; jump_id = 1'b0;
    rd_wb = 5'd0; reg_write_wb = 1'b0; wb_data = '0;
    flush_ex = 1'b0; stall_ex = 1'b0;
  endtask

  // Place a load "lw x<rd>, 0(x1)" in ID.
  task automatic id_load(input logic [4:0] rd, input logic [XLEN-1:0] pc);
    idle_inputs();
    valid_id = 1'b1; pc_id = pc; rs1_id = 5'd1; uses_rs1_id = 1'b1; rd_id = rd;
    mem_read_id = 1'b1; reg_write_id = 1'b1; mem_to_reg_id = 1'b1; alu_src_id = 1'b1;
  endtask

  // Place an ALU op "add x<rd>, x<r1>, x<r2>" in ID.
  task automatic id_add(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u2, input logic [XLEN-1:0] pc);
    idle_inputs();
    valid_id = 1'b1; pc_id = pc; rd_id = rd; rs1_id = r1; rs2_id = r2;
    uses_rs1_id = 1'b1; uses_rs2_id = u2; reg_write_id = 1'b1;
    rs1_data_id = 32'h0000_1111; rs2_data_id = 32'h0000_2222;
  endtask

  task automatic test_reset();
    valid_id = 1'b1; pc_id = 32'hFFFF_FFF0; rs1_id = 5'd3; rs2_id = 5'd4; rd_id = 5'd5;
    uses_rs1_id = 1'b1; uses_rs2_id = 1'b1; rs1_data_id = 32'h1; rs2_data_id = 32'h2;
    imm_id = 32'h3; alu_op_id = 4'hF; alu_src_id = 1'b1; mem_read_id = 1'b1;
    mem_write_id = 1'b1; reg_write_id = 1'b1; mem_to_reg_id = 1'b1; branch_id = 1'b1;
    jump_id = 1'b1; rd_wb = 5'd3; reg_write_wb = 1'b1; wb_data = 32'h9;
    flush_ex = 1'b1; stall_ex = 1'b1;
    rst = 1'b1;
    step();
    tests++;
    if ({valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex} !== '0) begin
      fails++; $display("FAIL reset_data: got valid=%0b pc=%0h d1=%0h d2=%0h imm=%0h, want all 0",
                        valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex);
    end
    tests++;
    if ({rs1_ex, rs2_ex, rd_ex, alu_op_ex, alu_src_ex, mem_read_ex, mem_write_ex,
         reg_write_ex, mem_to_reg_ex, branch_ex, jump_ex} !== '0) begin
      fails++; $display("FAIL reset_ctrl: got rs1=%0d rs2=%0d rd=%0d alu=%0h ctl=%b, want all 0",
                        rs1_ex, rs2_ex, rd_ex, alu_op_ex,
                        {alu_src_ex, mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex, branch_ex, jump_ex});
    end
    tests++;
    if (bubble_count !== '0) begin
      fails++; $display("FAIL reset_count: got %0d want 0", bubble_count);
    end
    tests++;
    if ({load_use_hazard, stall_if_id} !== 2'b00) begin
      fails++; $display("FAIL reset_comb: got hazard=%0b stall=%0b want 0 0", load_use_hazard, stall_if_id);
    end
    idle_inputs();
  endtask

  task automatic test_capture();
    idle_inputs();
    valid_id = 1'b1; pc_id = 32'h100; rd_id = 5'd5; reg_write_id = 1'b1;
    rs1_id = 5'd1; rs1_data_id = 32'h11;
    #1;
    tests++;
    if (stall_if_id !== 1'b0) begin
      fails++; $display("FAIL capture_stall: got %0b want 0", stall_if_id);
    end
    step();
    tests++;
    if ({valid_ex, pc_ex, rd_ex, rs1_data_ex, reg_write_ex} !== {1'b1, 32'h100, 5'd5, 32'h11, 1'b1}) begin
      fails++; $display("FAIL capture_fields: got valid=%0b pc=%0h rd=%0d d1=%0h rw=%0b want 1 100 5 11 1",
                        valid_ex, pc_ex, rd_ex, rs1_data_ex, reg_write_ex);
    end
  endtask

  task automatic test_load_use();
    id_load(5'd3, 32'h200);
    step();
    id_add(5'd6, 5'd4, 5'd3, 1'b1, 32'h204);
    #1;
    tests++;
    if ({load_use_hazard, stall_if_id} !== 2'b11) begin
      fails++; $display("FAIL lu_detect: got hazard=%0b stall=%0b want 1 1", load_use_hazard, stall_if_id);
    end
    step();
    tests++;
    if ({valid_ex, rd_ex, mem_read_ex, reg_write_ex} !== {1'b0, 5'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL lu_bubble: got valid=%0b rd=%0d mr=%0b rw=%0b want 0 0 0 0",
                        valid_ex, rd_ex, mem_read_ex, reg_write_ex);
    end
    tests++;
    if (bubble_count !== 4'd1) begin
      fails++; $display("FAIL lu_count: got %0d want 1", bubble_count);
    end
    tests++;
    if ({load_use_hazard, stall_if_id} !== 2'b00) begin
      fails++; $display("FAIL lu_release: got hazard=%0b stall=%0b want 0 0", load_use_hazard, stall_if_id);
    end
    step();
    tests++;
    if ({valid_ex, pc_ex, rd_ex, rs2_ex} !== {1'b1, 32'h204, 5'd6, 5'd3}) begin
      fails++; $display("FAIL lu_capture: got valid=%0b pc=%0h rd=%0d rs2=%0d want 1 204 6 3",
                        valid_ex, pc_ex, rd_ex, rs2_ex);
    end
  endtask

  task automatic test_false_hazard();
    id_load(5'd3, 32'h300);
    step();
    id_add(5'd6, 5'd4, 5'd3, 1'b0, 32'h304);
    #1;
    tests++;
    if ({load_use_hazard, stall_if_id} !== 2'b00) begin
      fails++; $display("FAIL fh_unused_rs2: got hazard=%0b stall=%0b want 0 0", load_use_hazard, stall_if_id);
    end
    step();
    tests++;
    if ({valid_ex, pc_ex} !== {1'b1, 32'h304}) begin
      fails++; $display("FAIL fh_capture: got valid=%0b pc=%0h want 1 304", valid_ex, pc_ex);
    end
    id_load(5'd0, 32'h308);
    step();
    id_add(5'd6, 5'd0, 5'd0, 1'b1, 32'h30C);
    #1;
    tests++;
    if ({load_use_hazard, stall_if_id} !== 2'b00) begin
      fails++; $display("FAIL fh_rd_x0: got hazard=%0b stall=%0b want 0 0", load_use_hazard, stall_if_id);
    end
    step();
    tests++;
    if (bubble_count !== 4'd1) begin
      fails++; $display("FAIL fh_count: got %0d want 1", bubble_count);
    end
  endtask

  task automatic test_wb_bypass();
    idle_inputs();
    valid_id = 1'b1; rs1_id = 5'd7; rs1_data_id = 32'hAAAA; rs2_id = 5'd8; rs2_data_id = 32'hBBBB;
    reg_write_wb = 1'b1; rd_wb = 5'd7; wb_data = 32'h1234;
    step();
    tests++;
    if ({rs1_data_ex, rs2_data_ex} !== {32'h1234, 32'hBBBB}) begin
      fails++; $display("FAIL byp_rs1: got d1=%0h d2=%0h want 1234 bbbb", rs1_data_ex, rs2_data_ex);
    end
    rd_wb = 5'd8;
    step();
    tests++;
    if ({rs1_data_ex, rs2_data_ex} !== {32'hAAAA, 32'h1234}) begin
      fails++; $display("FAIL byp_rs2: got d1=%0h d2=%0h want aaaa 1234", rs1_data_ex, rs2_data_ex);
    end
    rd_wb = 5'd0;
    step();
    tests++;
    if (rs1_data_ex !== 32'hAAAA) begin
      fails++; $display("FAIL byp_rdwb0: got %0h want aaaa", rs1_data_ex);
    end
    rs1_id = 5'd0;
    step();
    tests++;
    if (rs1_data_ex !== 32'hAAAA) begin
      fails++; $display("FAIL byp_x0: got %0h want aaaa", rs1_data_ex);
    end
  endtask

  task automatic test_flush_vs_stall();
    int c0;
    c0 = int'(bubble_count);
    id_load(5'd3, 32'h400);
    step();
    id_add(5'd6, 5'd4, 5'd3, 1'b1, 32'h404);
    flush_ex = 1'b1; stall_ex = 1'b1;
    #1;
    tests++;
    if ({load_use_hazard, stall_if_id} !== 2'b10) begin
      fails++; $display("FAIL fvs_comb: got hazard=%0b stall=%0b want 1 0", load_use_hazard, stall_if_id);
    end
    step();
    tests++;
    if ({valid_ex, rd_ex, mem_read_ex} !== {1'b0, 5'd0, 1'b0} || int'(bubble_count) != c0) begin
      fails++; $display("FAIL fvs_bubble: got valid=%0b rd=%0d mr=%0b cnt=%0d want 0 0 0 %0d",
                        valid_ex, rd_ex, mem_read_ex, bubble_count, c0);
    end
    // Capture an instruction, then hold it for three cycles.
    id_add(5'd10, 5'd8, 5'd9, 1'b1, 32'h300);
    rs1_data_id = 32'h4444; rs2_data_id = 32'h5555; imm_id = 32'h77;
    step();
    id_add(5'd20, 5'd21, 5'd22, 1'b1, 32'h999);
    stall_ex = 1'b1;
    #1;
    tests++;
    if (stall_if_id !== 1'b1) begin
      fails++; $display("FAIL hold_stall_out: got %0b want 1", stall_if_id);
    end
    for (int i = 0; i < 3; i++) begin
      reg_write_wb = (i == 1); rd_wb = 5'd9; wb_data = 32'hBEEF;
      step();
      tests++;
      if ({valid_ex, pc_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, imm_ex, reg_write_ex} !==
          {1'b1, 32'h300, 5'd8, 5'd9, 5'd10, 32'h4444, 32'h77, 1'b1}) begin
        fails++; $display("FAIL hold_fields[%0d]: got valid=%0b pc=%0h rs1=%0d rs2=%0d rd=%0d d1=%0h imm=%0h",
                          i, valid_ex, pc_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, imm_ex);
      end
      tests++;
      if (rs2_data_ex !== ((i == 0) ? 32'h5555 : 32'hBEEF)) begin
        fails++; $display("FAIL hold_refresh[%0d]: got %0h want %0h", i, rs2_data_ex,
                          (i == 0) ? 32'h5555 : 32'hBEEF);
      end
    end
    stall_ex = 1'b0; reg_write_wb = 1'b0;
    step();
    tests++;
    if ({valid_ex, pc_ex, rd_ex} !== {1'b1, 32'h999, 5'd20}) begin
      fails++; $display("FAIL hold_release: got valid=%0b pc=%0h rd=%0d want 1 999 20", valid_ex, pc_ex, rd_ex);
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      id_load(5'd3, 32'h500);
      step();
      id_add(5'd6, 5'd3, 5'd4, 1'b0, 32'h504);
      step();
      if (i == 14 || i == 20) begin
        tests++;
        if (int'(bubble_count) != ((i < CMAX) ? i : CMAX)) begin
          fails++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, bubble_count, (i < CMAX) ? i : CMAX);
        end
      end
    end
  endtask

  task automatic test_random();
    logic hz;
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m = '{valid: 1'b0, pc: '0, d1: '0, d2: '0, imm: '0, rs1: '0, rs2: '0, rd: '0, alu_op: '0,
          alu_src: 1'b0, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0,
          branch: 1'b0, jump: 1'b0, known: 1'b1, cnt: 0};
    for (int cyc = 0; cyc < 2000; cyc++) begin
      valid_id = ($urandom_range(0, 3) != 0);
      pc_id = $urandom; imm_id = $urandom; rs1_data_id = $urandom; rs2_data_id = $urandom;
      rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3)); rd_id = 5'($urandom_range(0, 3));
      uses_rs1_id = 1'($urandom); uses_rs2_id = 1'($urandom);
      alu_op_id = 4'($urandom); alu_src_id = 1'($urandom); mem_read_id = 1'($urandom);
      mem_write_id = 1'($urandom); reg_write_id = 1'($urandom); mem_to_reg_id = 1'($urandom);
      branch_id = 1'($urandom); jump_id = 1'($urandom);
      rd_wb = 5'($urandom_range(0, 3)); reg_write_wb = 1'($urandom); wb_data = $urandom;
      flush_ex = ($urandom_range(0, 15) == 0);
      stall_ex = ($urandom_range(0, 7) == 0);
      #1;
      // A load in EX with a real destination that the ID instruction reads.
      hz = m.valid && m.mem_read && (m.rd != 0) && valid_id &&
           ((uses_rs1_id && m.rd == rs1_id) || (uses_rs2_id && m.rd == rs2_id));
      tests++;
      if (load_use_hazard !== hz) begin
        fails++; $display("FAIL rnd_hazard@%0d: got %0b want %0b", cyc, load_use_hazard, hz);
      end
      tests++;
      if (stall_if_id !== ((hz || stall_ex) && !flush_ex)) begin
        fails++; $display("FAIL rnd_stall@%0d: got %0b want %0b", cyc, stall_if_id, (hz || stall_ex) && !flush_ex);
      end
      if (!flush_ex && stall_ex) begin
        if (reg_write_wb && rd_wb != 0 && rd_wb == m.rs1) m.d1 = wb_data;
        if (reg_write_wb && rd_wb != 0 && rd_wb == m.rs2) m.d2 = wb_data;
      end else if (!flush_ex && !hz && valid_id) begin
        m.valid = 1'b1; m.known = 1'b1; m.pc = pc_id; m.imm = imm_id;
        m.d1 = (reg_write_wb && rd_wb != 0 && rd_wb == rs1_id) ? wb_data : rs1_data_id;
        m.d2 = (reg_write_wb && rd_wb != 0 && rd_wb == rs2_id) ? wb_data : rs2_data_id;
        m.rs1 = rs1_id; m.rs2 = rs2_id; m.rd = rd_id; m.alu_op = alu_op_id;
        m.alu_src = alu_src_id; m.mem_read = mem_read_id; m.mem_write = mem_write_id;
        m.reg_write = reg_write_id; m.mem_to_reg = mem_to_reg_id; m.branch = branch_id; m.jump = jump_id;
      end else begin
        // Flush, load-use bubble, or an empty ID slot: EX becomes a bubble.
        m.valid = 1'b0; m.known = 1'b0; m.rs1 = 0; m.rs2 = 0; m.rd = 0;
        m.mem_read = 1'b0; m.mem_write = 1'b0; m.reg_write = 1'b0; m.branch = 1'b0; m.jump = 1'b0;
        if (!flush_ex && hz && m.cnt < CMAX) m.cnt++;
      end
      step();
      tests++;
      if ({valid_ex, rs1_ex, rs2_ex, rd_ex} !== {m.valid, m.rs1, m.rs2, m.rd}) begin
        fails++; $display("FAIL rnd_idx@%0d: got v=%0b %0d %0d %0d want v=%0b %0d %0d %0d", cyc,
                          valid_ex, rs1_ex, rs2_ex, rd_ex, m.valid, m.rs1, m.rs2, m.rd);
      end
      tests++;
      if ({reg_write_ex, mem_read_ex, mem_write_ex, branch_ex, jump_ex} !==
          {m.reg_write, m.mem_read, m.mem_write, m.branch, m.jump}) begin
        fails++; $display("FAIL rnd_ctrl@%0d: got %b want %b", cyc,
                          {reg_write_ex, mem_read_ex, mem_write_ex, branch_ex, jump_ex},
                          {m.reg_write, m.mem_read, m.mem_write, m.branch, m.jump});
      end
      tests++;
      if (bubble_count !== CW'(m.cnt)) begin
        fails++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, bubble_count, m.cnt);
      end
      if (m.known) begin
        tests++;
        if ({pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, alu_op_ex, alu_src_ex, mem_to_reg_ex} !==
            {m.pc, m.d1, m.d2, m.imm, m.alu_op, m.alu_src, m.mem_to_reg}) begin
          fails++; $display("FAIL rnd_data@%0d: got pc=%0h d1=%0h d2=%0h imm=%0h alu=%0h want %0h %0h %0h %0h %0h",
                            cyc, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, alu_op_ex,
                            m.pc, m.d1, m.d2, m.imm, m.alu_op);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_capture();
    test_load_use();
    test_false_hazard();
    test_wb_bypass();
    test_flush_vs_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
